// File: rtl/multiply_pkg.sv
// Shared helpers and types for the multiply arbiter: width math and grant FSM states.
package multiply_pkg;

    function automatic int log2Ceil(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return (result < 1) ? 1 : result;
    endfunction

    // Result keeps the integer bits of both operands plus Q fraction bits.
    function automatic int resultWidth(input int w, input int q);
        return 2 * w - q;
    endfunction

    typedef enum logic [0:0] {
        GRANT_IDLE  = 1'b0,
        GRANT_ISSUE = 1'b1
    } grantState_e;

endpackage

// File: rtl/multiply_tag_fifo.sv
// In-order FIFO of requester tags, one entry per multiply operation in flight.
module multiply_tag_fifo import multiply_pkg::*; #(
    parameter  int TAG_W = 2,
    parameter  int D     = 4,
    localparam int PW    = log2Ceil(D),
    localparam int CW    = log2Ceil(D + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [TAG_W-1:0] pushTag_i,
    input  logic             pop_i,
    output logic [TAG_W-1:0] headTag_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [TAG_W-1:0] mem_q [D];
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign full_o    = (count_q == CW'(D));
    assign empty_o   = (count_q == '0);
    assign headTag_o = mem_q[rdPtr_q];

    // A push while full is accepted only when a pop frees the slot in the same cycle.
    assign doPush = push_i && (!full_o || pop_i);
    assign doPop  = pop_i && !empty_o;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = (wrPtr_q == PW'(D - 1)) ? '0 : wrPtr_q + 1'b1;
        end
        if (doPop) begin
            rdPtr_d = (rdPtr_q == PW'(D - 1)) ? '0 : rdPtr_q + 1'b1;
        end
        case ({doPush, doPop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushTag_i;
        end
    end

endmodule

// File: rtl/multiply_arbiter.sv
// Round-robin sharing of one stb/rdy multiplier among N requesters, with results
// steered back to their issuers through an in-order tag FIFO.
module multiply_arbiter import multiply_pkg::*; #(
    parameter  int N     = 4,
    parameter  int W     = 16,
    parameter  int Q     = 8,
    parameter  int D     = 4,
    localparam int RW    = resultWidth(W, Q),
    localparam int TAG_W = log2Ceil(N)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_arg_stb,
    input  logic [N*2*W-1:0]     req_arg_dat,
    output logic [N-1:0]         req_arg_rdy,
    output logic [N-1:0]         req_res_stb,
    output logic [RW-1:0]        req_res_dat,
    input  logic [N-1:0]         req_res_rdy,
    output logic                 mul_arg_stb,
    output logic [2*W-1:0]       mul_arg_dat,
    input  logic                 mul_arg_rdy,
    input  logic                 mul_res_stb,
    input  logic [RW-1:0]        mul_res_dat,
    output logic                 mul_res_rdy
);

    if (N < 2) begin : gBadN
        $error("multiply_arbiter: N must be at least 2");
    end
    if (D < 1) begin : gBadD
        $error("multiply_arbiter: D must be at least 1");
    end
    if ((Q < 1) || (Q > W)) begin : gBadQ
        $error("multiply_arbiter: Q must lie in 1..W");
    end

    grantState_e      state_q, state_d;
    logic [TAG_W-1:0] grant_q, grant_d;
    logic [TAG_W-1:0] ptr_q, ptr_d;
    logic             pickValid;
    logic [TAG_W-1:0] pickIdx;
    logic             fifoPush;
    logic             fifoPop;
    logic             fifoFull;
    logic             fifoEmpty;
    logic [TAG_W-1:0] headTag;

    function automatic logic [TAG_W-1:0] wrapIndex(input int value);
        return TAG_W'(value % N);
    endfunction

    // First strobing requester at or after the round-robin pointer.
    always_comb begin
        pickValid = 1'b0;
        pickIdx   = '0;
        for (int i = 0; i < N; i++) begin
            if (!pickValid && req_arg_stb[wrapIndex(int'(ptr_q) + i)]) begin
                pickValid = 1'b1;
                pickIdx   = wrapIndex(int'(ptr_q) + i);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ptr_d       = ptr_q;
        mul_arg_stb = 1'b0;
        req_arg_rdy = '0;
        fifoPush    = 1'b0;
        unique case (state_q)
            GRANT_IDLE: begin
                if (pickValid && !fifoFull) begin
                    grant_d = pickIdx;
                    state_d = GRANT_ISSUE;
                end
            end
            GRANT_ISSUE: begin
                mul_arg_stb = 1'b1;
                if (mul_arg_rdy) begin
                    req_arg_rdy[grant_q] = 1'b1;
                    fifoPush             = 1'b1;
                    ptr_d                = wrapIndex(int'(grant_q) + 1);
                    state_d              = GRANT_IDLE;
                end
            end
            default: state_d = GRANT_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= GRANT_IDLE;
            grant_q <= '0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            ptr_q   <= ptr_d;
        end
    end

    assign mul_arg_dat = req_arg_dat[int'(grant_q) * 2 * W +: 2 * W];

    // Results belong to the oldest issued tag; with no owner nothing is accepted.
    always_comb begin
        req_res_stb = '0;
        mul_res_rdy = 1'b0;
        if (!fifoEmpty) begin
            req_res_stb[headTag] = mul_res_stb;
            mul_res_rdy          = req_res_rdy[headTag];
        end
    end

    assign req_res_dat = mul_res_dat;
    assign fifoPop     = mul_res_stb && mul_res_rdy;

    multiply_tag_fifo #(
        .TAG_W (TAG_W),
        .D     (D)
    ) tagFifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push_i    (fifoPush),
        .pushTag_i (grant_q),
        .pop_i     (fifoPop),
        .headTag_o (headTag),
        .full_o    (fifoFull),
        .empty_o   (fifoEmpty)
    );

    resultWithoutOwner: assert property (
        @(posedge clk) disable iff (!rst_n) !(mul_res_stb && fifoEmpty)
    );

endmodule

// File: tb/tb_multiply_arbiter.sv
// Directed self-checking bench for multiply_arbiter; the bench itself plays the multiplier.
module tb_multiply_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int Q  = 8;
    localparam int D  = 4;
    localparam int RW = 2 * W - Q;

    logic             clk;
    logic             rst_n;
    logic [N-1:0]     req_arg_stb;
    logic [N*2*W-1:0] req_arg_dat;
    logic [N-1:0]     req_arg_rdy;
    logic [N-1:0]     req_res_stb;
    logic [RW-1:0]    req_res_dat;
    logic [N-1:0]     req_res_rdy;
    logic             mul_arg_stb;
    logic [2*W-1:0]   mul_arg_dat;
    logic             mul_arg_rdy;
    logic             mul_res_stb;
    logic [RW-1:0]    mul_res_dat;
    logic             mul_res_rdy;

    int assertCount = 0;
    int failCount   = 0;

    multiply_arbiter #(.N(N), .W(W), .Q(Q), .D(D)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_arg_stb (req_arg_stb),
        .req_arg_dat (req_arg_dat),
        .req_arg_rdy (req_arg_rdy),
        .req_res_stb (req_res_stb),
        .req_res_dat (req_res_dat),
        .req_res_rdy (req_res_rdy),
        .mul_arg_stb (mul_arg_stb),
        .mul_arg_dat (mul_arg_dat),
        .mul_arg_rdy (mul_arg_rdy),
        .mul_res_stb (mul_res_stb),
        .mul_res_dat (mul_res_dat),
        .mul_res_rdy (mul_res_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        req_arg_stb = '0;
        req_arg_dat = '0;
        req_res_rdy = '0;
        mul_arg_rdy = 1'b0;
        mul_res_stb = 1'b0;
        mul_res_dat = '0;
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        clearInputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Presents one argument from requester idx alone and expects it to be granted.
    task automatic issueOne(input int idx, input logic [2*W-1:0] data);
        req_arg_dat[idx*2*W +: 2*W] = data;
        req_arg_stb = 4'(1 << idx);
        tick();
        assertCount++;
        if ({mul_arg_stb, req_arg_rdy, mul_arg_dat} !== {1'b1, 4'(1 << idx), data}) begin
            failCount++;
            $display("[TB] FAIL issue_req%0d: got stb=%b rdy=%b dat=%h expected stb=1 rdy=%b dat=%h",
                     idx, mul_arg_stb, req_arg_rdy, mul_arg_dat, 4'(1 << idx), data);
        end
        tick();
        req_arg_stb = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        clearInputs();
        req_arg_stb = '1;
        req_res_rdy = '1;
        mul_arg_rdy = 1'b1;
        tick();
        tick();
        assertCount++;
        if ({mul_arg_stb, req_arg_rdy, req_res_stb, mul_res_rdy} !== 10'b0) begin
            failCount++;
            $display("[TB] FAIL reset_outputs: got argStb=%b argRdy=%b resStb=%b resRdy=%b expected all 0",
                     mul_arg_stb, req_arg_rdy, req_res_stb, mul_res_rdy);
        end
        assertCount++;
        if (dut.tagFifo.count_q !== 3'd0) begin
            failCount++;
            $display("[TB] FAIL reset_count: got %0d expected 0", dut.tagFifo.count_q);
        end
        rst_n = 1'b1;
        clearInputs();
    endtask

    task automatic test_single();
        applyReset();
        mul_arg_rdy = 1'b1;
        req_arg_dat[1*2*W +: 2*W] = 32'h0300_0200;
        req_arg_stb = 4'b0010;
        #1;
        assertCount++;
        if (mul_arg_stb !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL single_arb_latency: got mul_arg_stb=%b expected 0", mul_arg_stb);
        end
        tick();
        assertCount++;
        if ({mul_arg_stb, req_arg_rdy, mul_arg_dat} !== {1'b1, 4'b0010, 32'h0300_0200}) begin
            failCount++;
            $display("[TB] FAIL single_issue: got stb=%b rdy=%b dat=%h expected stb=1 rdy=0010 dat=03000200",
                     mul_arg_stb, req_arg_rdy, mul_arg_dat);
        end
        tick();
        req_arg_stb = '0;
        mul_res_stb = 1'b1;
        mul_res_dat = 24'h000600;
        req_res_rdy = 4'b1111;
        #1;
        assertCount++;
        if ({req_res_stb, req_res_dat, mul_res_rdy} !== {4'b0010, 24'h000600, 1'b1}) begin
            failCount++;
            $display("[TB] FAIL single_result: got stb=%b dat=%h rdy=%b expected stb=0010 dat=000600 rdy=1",
                     req_res_stb, req_res_dat, mul_res_rdy);
        end
        tick();
        mul_res_stb = 1'b0;
        tick();
        assertCount++;
        if (mul_arg_stb !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL single_no_regrant: got mul_arg_stb=%b expected 0", mul_arg_stb);
        end
    endtask

    task automatic test_round_robin();
        int rdyCount [N];
        applyReset();
        for (int i = 0; i < N; i++) begin
            req_arg_dat[i*2*W +: 2*W] = 32'hA000_0000 | 32'(i);
            rdyCount[i] = 0;
        end
        req_arg_stb = '1;
        mul_arg_rdy = 1'b1;
        req_res_rdy = '1;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) begin
                mul_res_stb = 1'b1;
                mul_res_dat = RW'(k);
                #1;
                assertCount++;
                if (req_res_stb !== 4'(1 << ((k - 1) % N))) begin
                    failCount++;
                    $display("[TB] FAIL rr_result_%0d: got res_stb=%b expected %b",
                             k, req_res_stb, 4'(1 << ((k - 1) % N)));
                end
            end
            tick();
            mul_res_stb = 1'b0;
            #1;
            for (int i = 0; i < N; i++) if (req_arg_rdy[i]) rdyCount[i]++;
            assertCount++;
            if ({mul_arg_stb, req_arg_rdy, mul_arg_dat} !== {1'b1, 4'(1 << (k % N)), 32'hA000_0000 | 32'(k % N)}) begin
                failCount++;
                $display("[TB] FAIL rr_grant_%0d: got stb=%b rdy=%b dat=%h expected rdy=%b",
                         k, mul_arg_stb, req_arg_rdy, mul_arg_dat, 4'(1 << (k % N)));
            end
            tick();
        end
        for (int i = 0; i < N; i++) begin
            assertCount++;
            if (rdyCount[i] !== 2) begin
                failCount++;
                $display("[TB] FAIL rr_fairness_req%0d: got %0d grants expected 2", i, rdyCount[i]);
            end
        end
        req_arg_stb = '0;
    endtask

    task automatic test_arg_stall();
        applyReset();
        req_arg_dat[0*2*W +: 2*W] = 32'h1111_2222;
        req_arg_dat[2*2*W +: 2*W] = 32'h3333_4444;
        req_arg_stb = 4'b0101;
        tick();
        for (int c = 0; c < 5; c++) begin
            assertCount++;
            if ({mul_arg_stb, req_arg_rdy, mul_arg_dat} !== {1'b1, 4'b0000, 32'h1111_2222}) begin
                failCount++;
                $display("[TB] FAIL stall_hold_%0d: got stb=%b rdy=%b dat=%h expected stb=1 rdy=0000 dat=11112222",
                         c, mul_arg_stb, req_arg_rdy, mul_arg_dat);
            end
            tick();
        end
        mul_arg_rdy = 1'b1;
        #1;
        assertCount++;
        if (req_arg_rdy !== 4'b0001) begin
            failCount++;
            $display("[TB] FAIL stall_release: got rdy=%b expected 0001", req_arg_rdy);
        end
        tick();
        req_arg_stb = 4'b0100;
        tick();
        assertCount++;
        if ({req_arg_rdy, mul_arg_dat} !== {4'b0100, 32'h3333_4444}) begin
            failCount++;
            $display("[TB] FAIL stall_next_grant: got rdy=%b dat=%h expected rdy=0100 dat=33334444",
                     req_arg_rdy, mul_arg_dat);
        end
        tick();
        req_arg_stb = '0;
    endtask

    task automatic test_fifo_full();
        applyReset();
        req_arg_stb = '1;
        mul_arg_rdy = 1'b1;
        for (int k = 0; k < D; k++) begin
            tick();
            assertCount++;
            if (req_arg_rdy !== 4'(1 << k)) begin
                failCount++;
                $display("[TB] FAIL full_fill_%0d: got rdy=%b expected %b", k, req_arg_rdy, 4'(1 << k));
            end
            tick();
        end
        for (int c = 0; c < 3; c++) begin
            assertCount++;
            if (mul_arg_stb !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL full_blocked_%0d: got mul_arg_stb=%b expected 0", c, mul_arg_stb);
            end
            tick();
        end
        mul_res_stb = 1'b1;
        mul_res_dat = 24'h000100;
        req_res_rdy = 4'b0001;
        #1;
        assertCount++;
        if ({req_res_stb, mul_res_rdy} !== {4'b0001, 1'b1}) begin
            failCount++;
            $display("[TB] FAIL full_pop: got res_stb=%b res_rdy=%b expected 0001 1", req_res_stb, mul_res_rdy);
        end
        tick();
        mul_res_stb = 1'b0;
        req_res_rdy = '0;
        #1;
        assertCount++;
        if (mul_arg_stb !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL full_after_pop_arb: got mul_arg_stb=%b expected 0", mul_arg_stb);
        end
        tick();
        assertCount++;
        if ({mul_arg_stb, req_arg_rdy} !== {1'b1, 4'b0001}) begin
            failCount++;
            $display("[TB] FAIL full_regrant: got stb=%b rdy=%b expected 1 0001", mul_arg_stb, req_arg_rdy);
        end
        tick();
        for (int c = 0; c < 3; c++) begin
            assertCount++;
            if (mul_arg_stb !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL full_single_regrant_%0d: got mul_arg_stb=%b expected 0", c, mul_arg_stb);
            end
            tick();
        end
        req_arg_stb = '0;
    endtask

    task automatic test_result_order();
        applyReset();
        mul_arg_rdy = 1'b1;
        issueOne(2, 32'hFF00_0100);
        issueOne(0, 32'h0200_0100);
        issueOne(3, 32'h0300_0100);
        mul_res_stb = 1'b1;
        mul_res_dat = 24'hFFFF00;
        req_res_rdy = 4'b1110;
        #1;
        assertCount++;
        if ({req_res_stb, req_res_dat, mul_res_rdy} !== {4'b0100, 24'hFFFF00, 1'b1}) begin
            failCount++;
            $display("[TB] FAIL order_tag2: got stb=%b dat=%h rdy=%b expected 0100 ffff00 1",
                     req_res_stb, req_res_dat, mul_res_rdy);
        end
        tick();
        mul_res_dat = 24'h000200;
        #1;
        for (int c = 0; c < 3; c++) begin
            assertCount++;
            if ({req_res_stb, mul_res_rdy} !== {4'b0001, 1'b0}) begin
                failCount++;
                $display("[TB] FAIL order_stall_tag0_%0d: got stb=%b rdy=%b expected 0001 0",
                         c, req_res_stb, mul_res_rdy);
            end
            tick();
        end
        req_res_rdy = 4'b1111;
        #1;
        assertCount++;
        if ({req_res_stb, mul_res_rdy} !== {4'b0001, 1'b1}) begin
            failCount++;
            $display("[TB] FAIL order_tag0: got stb=%b rdy=%b expected 0001 1", req_res_stb, mul_res_rdy);
        end
        tick();
        mul_res_dat = 24'h000300;
        #1;
        assertCount++;
        if ({req_res_stb, req_res_dat, mul_res_rdy} !== {4'b1000, 24'h000300, 1'b1}) begin
            failCount++;
            $display("[TB] FAIL order_tag3: got stb=%b dat=%h rdy=%b expected 1000 000300 1",
                     req_res_stb, req_res_dat, mul_res_rdy);
        end
        tick();
        mul_res_stb = 1'b0;
        assertCount++;
        if (dut.tagFifo.count_q !== 3'd0) begin
            failCount++;
            $display("[TB] FAIL order_drained: got count=%0d expected 0", dut.tagFifo.count_q);
        end
    endtask

    task automatic test_reset_mid();
        applyReset();
        mul_arg_rdy = 1'b1;
        issueOne(0, 32'h0100_0100);
        issueOne(1, 32'h0200_0100);
        issueOne(2, 32'h0300_0100);
        assertCount++;
        if (dut.tagFifo.count_q !== 3'd3) begin
            failCount++;
            $display("[TB] FAIL midreset_inflight: got count=%0d expected 3", dut.tagFifo.count_q);
        end
        rst_n = 1'b0;
        req_arg_stb = '1;
        req_res_rdy = '1;
        mul_res_stb = 1'b1;
        tick();
        assertCount++;
        if ({mul_arg_stb, req_arg_rdy, req_res_stb, mul_res_rdy} !== 10'b0) begin
            failCount++;
            $display("[TB] FAIL midreset_outputs: got argStb=%b argRdy=%b resStb=%b resRdy=%b expected all 0",
                     mul_arg_stb, req_arg_rdy, req_res_stb, mul_res_rdy);
        end
        assertCount++;
        if (dut.tagFifo.count_q !== 3'd0) begin
            failCount++;
            $display("[TB] FAIL midreset_count: got count=%0d expected 0", dut.tagFifo.count_q);
        end
        mul_res_stb = 1'b0;
        rst_n = 1'b1;
        tick();
        assertCount++;
        if (req_arg_rdy !== 4'b0001) begin
            failCount++;
            $display("[TB] FAIL midreset_ptr: got rdy=%b expected 0001", req_arg_rdy);
        end
        tick();
        req_arg_stb = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        clearInputs();
        test_reset();
        test_single();
        test_round_robin();
        test_arg_stall();
        test_fifo_full();
        test_result_order();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
